id_ex_latch: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline. It sits between decode and execute, and captures decoded control, operands, immediate and register specifiers every cycle. Its rs/rt/write-back outputs drive the EX-stage forwarding logic. When a load in EX feeds the instruction in ID, it inserts a one-cycle bubble and freezes PC and IF/ID. A branch-taken flush also inserts a bubble.

---
 rtl/id_ex_latch.sv | 116 +++++++++++
 tb/tb_id_ex_latch.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline, with load-use hazard
// detection that stalls PC and IF/ID and injects a single-cycle bubble.
module id_ex_latch #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [1:0]    ctlwb_in,
    input  logic [2:0]    ctlm_in,
    input  logic [3:0]    ctlex_in,
    input  logic [DW-1:0] npc_in,
    input  logic [DW-1:0] rdata1_in,
    input  logic [DW-1:0] rdata2_in,
    input  logic [DW-1:0] sext_in,
    input  logic [4:0]    rs_in,
    input  logic [4:0]    rt_in,
    input  logic [4:0]    rd_in,
    output logic [1:0]    wb_out,
    output logic [2:0]    m_out,
    output logic [3:0]    ex_out,
    output logic [DW-1:0] npc_out,
    output logic [DW-1:0] rdata1_out,
    output logic [DW-1:0] rdata2_out,
    output logic [DW-1:0] sext_out,
    output logic [4:0]    rs_out,
    output logic [4:0]    rt_out,
    output logic [4:0]    rd_out,
    output logic          pc_write,
    output logic          if_id_write,
    output logic [31:0]   stall_count
);

    logic [1:0]    wb_reg;
    logic [2:0]    m_reg;
    logic [3:0]    ex_reg;
    logic [DW-1:0] npc_reg;
    logic [DW-1:0] rdata1_reg;
    logic [DW-1:0] rdata2_reg;
    logic [DW-1:0] sext_reg;
    logic [4:0]    rs_reg;
    logic [4:0]    rt_reg;
    logic [4:0]    rd_reg;
    logic [31:0]   stall_count_reg;
    logic [31:0]   stall_count_next;

    logic          rt_match;
    logic          lu_hazard;
    logic          bubble;

    // A load in EX whose destination ($rt) is read by the instruction in ID;
    // a pending branch flush squashes that instruction, so it cannot stall.
    assign rt_match  = (rt_reg != 5'd0) && ((rt_reg == rs_in) || (rt_reg == rt_in));
    assign lu_hazard = m_reg[1] && rt_match && !flush;
    assign bubble    = flush || lu_hazard;

    assign pc_write    = !lu_hazard;
    assign if_id_write = !lu_hazard;

    always_comb begin
        stall_count_next = stall_count_reg;
        if (lu_hazard) begin
            stall_count_next = stall_count_reg + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_reg          <= '0;
            m_reg           <= '0;
            ex_reg          <= '0;
            npc_reg         <= '0;
            rdata1_reg      <= '0;
            rdata2_reg      <= '0;
            sext_reg        <= '0;
            rs_reg          <= '0;
            rt_reg          <= '0;
            rd_reg          <= '0;
            stall_count_reg <= '0;
        end else begin
            // Datapath always loads; zeroed controls make a bubble inert.
            npc_reg    <= npc_in;
            rdata1_reg <= rdata1_in;
            rdata2_reg <= rdata2_in;
            sext_reg   <= sext_in;
            rs_reg     <= rs_in;
            rt_reg     <= rt_in;
            rd_reg     <= rd_in;
            if (bubble) begin
                wb_reg <= '0;
                m_reg  <= '0;
                ex_reg <= '0;
            end else begin
                wb_reg <= ctlwb_in;
                m_reg  <= ctlm_in;
                ex_reg <= ctlex_in;
            end
            if (lu_hazard) begin
                stall_count_reg <= stall_count_next;
            end
        end
    end

    assign wb_out      = wb_reg;
    assign m_out       = m_reg;
    assign ex_out      = ex_reg;
    assign npc_out     = npc_reg;
    assign rdata1_out  = rdata1_reg;
    assign rdata2_out  = rdata2_reg;
    assign sext_out    = sext_reg;
    assign rs_out      = rs_reg;
    assign rt_out      = rt_reg;
    assign rd_out      = rd_reg;
    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_id_ex_latch.sv
// Directed bench for id_ex_latch: reset, pass-through, load-use stalls,
// $0 loads, flush priority, reset mid-stall and stall counter wrap.
module tb_id_ex_latch;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          flush;
    logic [1:0]    ctlwb_in;
    logic [2:0]    ctlm_in;
    logic [3:0]    ctlex_in;
    logic [DW-1:0] npc_in;
    logic [DW-1:0] rdata1_in;
    logic [DW-1:0] rdata2_in;
    logic [DW-1:0] sext_in;
    logic [4:0]    rs_in;
    logic [4:0]    rt_in;
    logic [4:0]    rd_in;
    logic [1:0]    wb_out;
    logic [2:0]    m_out;
    logic [3:0]    ex_out;
    logic [DW-1:0] npc_out;
    logic [DW-1:0] rdata1_out;
    logic [DW-1:0] rdata2_out;
    logic [DW-1:0] sext_out;
    logic [4:0]    rs_out;
    logic [4:0]    rt_out;
    logic [4:0]    rd_out;
    logic          pc_write;
    logic          if_id_write;
    logic [31:0]   stall_count;

    int checks;
    int errors;
    logic [31:0] exp_stall;

    id_ex_latch #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .ctlex_in(ctlex_in),
        .npc_in(npc_in), .rdata1_in(rdata1_in), .rdata2_in(rdata2_in),
        .sext_in(sext_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
        .wb_out(wb_out), .m_out(m_out), .ex_out(ex_out),
        .npc_out(npc_out), .rdata1_out(rdata1_out), .rdata2_out(rdata2_out),
        .sext_out(sext_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .pc_write(pc_write), .if_id_write(if_id_write), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] d1);
        ctlwb_in  = wb;
        ctlm_in   = m;
        ctlex_in  = ex;
        rs_in     = rs;
        rt_in     = rt;
        rd_in     = rd;
        rdata1_in = d1;
        rdata2_in = d1 ^ 32'hFFFF_0000;
        sext_in   = {27'd0, rd};
        npc_in    = d1 + 32'd4;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        drive(2'b11, 3'b111, 4'b1111, 5'd7, 5'd9, 5'd3, 32'hDEAD_BEEF);
        tick();
        tick();
        checks++;
        if ({wb_out, m_out, ex_out} !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctl got %h want 0", {wb_out, m_out, ex_out});
        end
        checks++;
        if ({npc_out, rdata1_out, rdata2_out, sext_out} !== 128'd0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", {npc_out, rdata1_out, rdata2_out, sext_out});
        end
        checks++;
        if ({rs_out, rt_out, rd_out} !== 15'd0 || stall_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_spec got %h cnt %h want 0", {rs_out, rt_out, rd_out}, stall_count);
        end
        checks++;
        if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall got %b%b want 11", pc_write, if_id_write);
        end
        $display("txn reset: ctl=%h cnt=%0d pc_write=%b", {wb_out, m_out, ex_out}, stall_count, pc_write);
        rst = 1'b0;
        exp_stall = 32'd0;
    endtask

    task automatic test_pass_through();
        drive(2'b10, 3'b000, 4'b1100, 5'd5, 5'd6, 5'd7, 32'h0000_1234);
        checks++;
        if (pc_write !== 1'b1) begin
            errors++;
            $display("FAIL pass_pcw got %b want 1", pc_write);
        end
        tick();
        checks++;
        if (wb_out !== 2'b10 || m_out !== 3'b000 || ex_out !== 4'b1100) begin
            errors++;
            $display("FAIL pass_ctl got %b %b %b want 10 000 1100", wb_out, m_out, ex_out);
        end
        checks++;
        if (rdata1_out !== 32'h1234 || rdata2_out !== 32'hFFFF_1234 ||
            npc_out !== 32'h1238 || sext_out !== 32'd7) begin
            errors++;
            $display("FAIL pass_data got %h %h %h %h", rdata1_out, rdata2_out, npc_out, sext_out);
        end
        checks++;
        if (rs_out !== 5'd5 || rt_out !== 5'd6 || rd_out !== 5'd7 || stall_count !== 32'd0) begin
            errors++;
            $display("FAIL pass_spec got %0d %0d %0d cnt %0d want 5 6 7 0", rs_out, rt_out, rd_out, stall_count);
        end
        $display("txn pass: wb=%b m=%b ex=%b rd1=%h rs=%0d", wb_out, m_out, ex_out, rdata1_out, rs_out);
    endtask

    task automatic test_load_use();
        drive(2'b11, 3'b010, 4'b0001, 5'd1, 5'd8, 5'd0, 32'h100);
        tick();
        drive(2'b10, 3'b000, 4'b1100, 5'd8, 5'd9, 5'd10, 32'h200);
        checks++;
        if (pc_write !== 1'b0 || if_id_write !== 1'b0) begin
            errors++;
            $display("FAIL lu_stall got %b%b want 00", pc_write, if_id_write);
        end
        tick();
        exp_stall = exp_stall + 32'd1;
        checks++;
        if ({wb_out, m_out, ex_out} !== 9'd0 || stall_count !== exp_stall) begin
            errors++;
            $display("FAIL lu_bubble got ctl %h cnt %0d want 0 %0d", {wb_out, m_out, ex_out}, stall_count, exp_stall);
        end
        checks++;
        if (pc_write !== 1'b1 || rs_out !== 5'd8) begin
            errors++;
            $display("FAIL lu_release got pcw %b rs %0d want 1 8", pc_write, rs_out);
        end
        tick();
        checks++;
        if (wb_out !== 2'b10 || ex_out !== 4'b1100 || stall_count !== exp_stall) begin
            errors++;
            $display("FAIL lu_resume got %b %b cnt %0d", wb_out, ex_out, stall_count);
        end
        $display("txn load_use: cnt=%0d wb=%b pc_write=%b", stall_count, wb_out, pc_write);
    endtask

    task automatic test_back_to_back();
        drive(2'b11, 3'b010, 4'b0001, 5'd2, 5'd10, 5'd0, 32'h300);
        tick();
        drive(2'b11, 3'b010, 4'b0001, 5'd10, 5'd11, 5'd0, 32'h304);
        checks++;
        if (pc_write !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall1 got %b want 0", pc_write);
        end
        tick();
        tick();
        checks++;
        if (m_out !== 3'b010 || rt_out !== 5'd11) begin
            errors++;
            $display("FAIL b2b_second got m %b rt %0d want 010 11", m_out, rt_out);
        end
        drive(2'b10, 3'b000, 4'b1100, 5'd3, 5'd11, 5'd12, 32'h308);
        checks++;
        if (pc_write !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall2 got %b want 0", pc_write);
        end
        tick();
        exp_stall = exp_stall + 32'd2;
        checks++;
        if (stall_count !== exp_stall || pc_write !== 1'b1) begin
            errors++;
            $display("FAIL b2b_count got %0d pcw %b want %0d 1", stall_count, pc_write, exp_stall);
        end
        tick();
        $display("txn back_to_back: cnt=%0d", stall_count);
    endtask

    task automatic test_zero_reg();
        drive(2'b11, 3'b010, 4'b0001, 5'd4, 5'd0, 5'd0, 32'h400);
        tick();
        drive(2'b10, 3'b000, 4'b1100, 5'd0, 5'd0, 5'd13, 32'h404);
        checks++;
        if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin
            errors++;
            $display("FAIL zero_stall got %b%b want 11", pc_write, if_id_write);
        end
        tick();
        checks++;
        if (stall_count !== exp_stall || wb_out !== 2'b10) begin
            errors++;
            $display("FAIL zero_count got %0d wb %b want %0d 10", stall_count, wb_out, exp_stall);
        end
        $display("txn zero_reg: cnt=%0d pc_write=%b", stall_count, pc_write);
    endtask

    task automatic test_flush();
        drive(2'b11, 3'b010, 4'b0001, 5'd4, 5'd12, 5'd0, 32'h500);
        tick();
        drive(2'b10, 3'b100, 4'b1100, 5'd12, 5'd1, 5'd14, 32'h504);
        flush = 1'b1;
        #1;
        checks++;
        if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin
            errors++;
            $display("FAIL flush_pcw got %b%b want 11", pc_write, if_id_write);
        end
        tick();
        flush = 1'b0;
        checks++;
        if ({wb_out, m_out, ex_out} !== 9'd0 || stall_count !== exp_stall) begin
            errors++;
            $display("FAIL flush_bubble got ctl %h cnt %0d want 0 %0d", {wb_out, m_out, ex_out}, stall_count, exp_stall);
        end
        $display("txn flush: ctl=%h cnt=%0d", {wb_out, m_out, ex_out}, stall_count);
    endtask

    task automatic test_reset_mid_stall();
        drive(2'b11, 3'b010, 4'b0001, 5'd4, 5'd13, 5'd0, 32'h600);
        tick();
        drive(2'b10, 3'b000, 4'b1100, 5'd13, 5'd1, 5'd15, 32'h604);
        rst = 1'b1;
        #1;
        checks++;
        if (pc_write !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_pre got %b want 0", pc_write);
        end
        tick();
        rst = 1'b0;
        exp_stall = 32'd0;
        checks++;
        if (pc_write !== 1'b1 || m_out !== 3'd0 || stall_count !== exp_stall) begin
            errors++;
            $display("FAIL rstmid_post got pcw %b m %b cnt %0d want 1 000 0", pc_write, m_out, stall_count);
        end
        $display("txn reset_mid_stall: pc_write=%b cnt=%0d", pc_write, stall_count);
    endtask

    task automatic test_wrap();
        drive(2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd3, 32'h700);
        force dut.stall_count_reg = 32'hFFFF_FFFF;
        tick();
        release dut.stall_count_reg;
        #1;
        checks++;
        if (stall_count !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preload got %h want ffffffff", stall_count);
        end
        drive(2'b11, 3'b010, 4'b0001, 5'd4, 5'd16, 5'd0, 32'h704);
        tick();
        drive(2'b10, 3'b000, 4'b1100, 5'd5, 5'd16, 5'd17, 32'h708);
        tick();
        checks++;
        if (stall_count !== 32'd0) begin
            errors++;
            $display("FAIL wrap_count got %h want 0", stall_count);
        end
        $display("txn wrap: cnt=%h", stall_count);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_stall = 32'd0;
        rst = 1'b1;
        flush = 1'b0;
        test_reset();
        test_pass_through();
        test_load_use();
        test_back_to_back();
        test_zero_reg();
        test_flush();
        test_reset_mid_stall();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
